// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch front end:
//               FSM state encoding, the PC increment and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // FSM states of the fetch sequencer
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force a redirect target onto a word boundary
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry {instr, pc} holding register that absorbs a fetched
//               instruction while the output register is occupied.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               push           - load push_instr/push_pc (wins over pop)
//               pop            - release the held entry
//               flush          - discard the held entry (wins over everything)
//               full           - an entry is held
//               instr, pc      - held entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= 32'd0;
      pc    <= 32'd0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= push_instr;
      pc    <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch front end. Owns the PC, issues one request
//               at a time to instruction memory and presents fetched words
//               with their PC and PC+4 to decode through an output register
//               backed by a one-entry skid slot.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               stall                      - decode cannot accept this cycle
//               branch_taken, branch_addr  - one-cycle redirect
//               imem_req/addr/gnt          - request handshake
//               imem_rvalid/rdata          - response (one per grant)
//               if_valid/instr/pc/pc_plus_4- decode-side output register
//               fetch_misalign             - sticky misaligned-redirect flag
// Config      : FETCH_MISALIGN_CHECK_EN - when defined, a misaligned redirect
//               raises fetch_misalign and parks the FSM in HALT; otherwise
//               the target is word-aligned and the flag is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic        fetch_misalign
);

  fetch_state_t state;
  logic [31:0]  pc;

  logic        consume;
  logic        capture;
  logic        cap_to_out;
  logic        skid_push;
  logic        skid_pop;
  logic        skid_full;
  logic        skid_full_next;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  assign imem_addr = pc;
  assign consume   = if_valid && !stall;
  // A response accepted in WAIT; a same-cycle redirect discards it
  assign capture   = (state == ST_WAIT) && imem_rvalid && !branch_taken;
  // The output register takes the capture only if it is free this cycle and
  // the skid is not ahead of it in line
  assign cap_to_out     = capture && (!if_valid || (consume && !skid_full));
  assign skid_push      = capture && !cap_to_out;
  assign skid_pop       = consume && skid_full && !branch_taken;
  assign skid_full_next = skid_push || (skid_full && !skid_pop);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (branch_taken),
    .push_instr (imem_rdata),
    .push_pc    (pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic drop_owed;

  // Remembers that a granted request is still due to answer while in HALT,
  // so its response is swallowed rather than mistaken for a new fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_owed <= 1'b0;
    end else if (branch_taken && (branch_addr[1:0] != 2'b00)) begin
      drop_owed <= ((state == ST_REQ)  && imem_gnt) ||
                   ((state == ST_WAIT) && !imem_rvalid) ||
                   ((state == ST_DROP) && !imem_rvalid) ||
                   ((state == ST_HALT) && drop_owed && !imem_rvalid);
    end else if (branch_taken || ((state == ST_HALT) && imem_rvalid)) begin
      drop_owed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misalign <= 1'b0;
    end else if (branch_taken) begin
      fetch_misalign <= (branch_addr[1:0] != 2'b00);
    end
  end
`else
  assign fetch_misalign = 1'b0;
`endif

  // Fetch sequencer; imem_req is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
    end else if (branch_taken) begin
      pc <= align_pc(branch_addr);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (branch_addr[1:0] != 2'b00) begin
        state    <= ST_HALT;
        imem_req <= 1'b0;
      end else
`endif
      begin
        case (state)
          // A grant this cycle means a response is still coming back
          ST_REQ: begin
            state    <= imem_gnt ? ST_DROP : ST_REQ;
            imem_req <= !imem_gnt;
          end
          ST_WAIT, ST_DROP: begin
            state    <= imem_rvalid ? ST_REQ : ST_DROP;
            imem_req <= imem_rvalid;
          end
`ifdef FETCH_MISALIGN_CHECK_EN
          ST_HALT: begin
            state    <= (drop_owed && !imem_rvalid) ? ST_DROP : ST_REQ;
            imem_req <= !(drop_owed && !imem_rvalid);
          end
`endif
          default: begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        endcase
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!skid_full) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_gnt) begin
            state    <= ST_WAIT;
            imem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            pc <= pc + PC_STEP;
            // Do not fetch further ahead while the skid is occupied
            state    <= skid_full_next ? ST_IDLE : ST_REQ;
            imem_req <= !skid_full_next;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= state;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Decode-side output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid     <= 1'b0;
      if_instr     <= 32'd0;
      if_pc        <= 32'd0;
      if_pc_plus_4 <= 32'd0;
    end else if (branch_taken) begin
      if_valid <= 1'b0;
    end else if (skid_pop) begin
      if_valid     <= 1'b1;
      if_instr     <= skid_instr;
      if_pc        <= skid_pc;
      if_pc_plus_4 <= skid_pc + PC_STEP;
    end else if (cap_to_out) begin
      if_valid     <= 1'b1;
      if_instr     <= imem_rdata;
      if_pc        <= pc;
      if_pc_plus_4 <= pc + PC_STEP;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. A per-cycle vector
//               table covers start-up and stall/skid behaviour; hand-written
//               sequences cover redirects, wraparound, misalignment and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        fetch_misalign;

  int tests;
  int fails;

  logic        gnt_en;
  logic [31:0] gnt_addr;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus_4   (if_pc_plus_4),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock; then the memory model updates: the grant of the cycle just
  // ended returns data now, and a new grant follows the current request.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rvalid = imem_gnt;
    imem_rdata  = mem_of(gnt_addr);
    imem_gnt    = imem_req && gnt_en;
    gnt_addr    = imem_addr;
  endtask

  task automatic expect_next(input logic [31:0] exp_pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_valid) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL timeout waiting for if_pc %h: no if_valid seen", exp_pc);
    end else begin
      chk("next_pc", if_pc, exp_pc);
      chk("next_instr", if_instr, mem_of(exp_pc));
      chk("next_pc_plus_4", if_pc_plus_4, exp_pc + 32'd4);
    end
  endtask

  task automatic redirect(input logic [31:0] addr);
    branch_taken = 1'b1;
    branch_addr  = addr;
    tick();
    branch_taken = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic found;
    tests = 0;
    fails = 0;

    //            stall valid pc      req   addr
    vecs[0]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'd0,  1'b1, 32'd4};
    vecs[3]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd4};
    vecs[4]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd8};
    vecs[5]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd8};
    vecs[6]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd12};
    vecs[7]  = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd12};
    vecs[8]  = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd16};
    vecs[9]  = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd16};
    vecs[10] = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd16};
    vecs[11] = '{1'b1, 1'b1, 32'd8,  1'b0, 32'd16};
    vecs[12] = '{1'b0, 1'b1, 32'd12, 1'b0, 32'd16};
    vecs[13] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
    vecs[14] = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd16};
    vecs[15] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd20};

    rst_n        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;
    gnt_en       = 1'b1;
    gnt_addr     = 32'd0;

    tick();
    tick();
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_addr", imem_addr, 32'd0);
    chk("reset_valid", 32'(if_valid), 32'd0);
    chk("reset_instr", if_instr, 32'd0);
    chk("reset_pc", if_pc, 32'd0);
    chk("reset_pc_plus_4", if_pc_plus_4, 32'd0);
    chk("reset_misalign", 32'(fetch_misalign), 32'd0);
    rst_n = 1'b1;

    // Start-up stream and a five-cycle stall with a response parked in skid
    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i), if_pc, vecs[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr, mem_of(vecs[i].pc));
        chk($sformatf("v%0d_pc_plus_4", i), if_pc_plus_4, vecs[i].pc + 32'd4);
      end
    end
    stall = 1'b0;

    // Redirect while waiting on the 0x20 response (which arrives that cycle)
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req && imem_addr == 32'h20) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL timeout waiting for request to 0x20");
    end
    stall = 1'b1;
    tick();
    chk("wait_hold_valid", 32'(if_valid), 32'd1);
    chk("wait_hold_pc", if_pc, 32'h1C);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("br_wait_valid", 32'(if_valid), 32'd0);
    chk("br_wait_req", 32'(imem_req), 32'd1);
    chk("br_wait_addr", imem_addr, 32'h100);
    expect_next(32'h100);

    // Redirect in REQ with a grant the same cycle: stale response is dropped
    redirect(32'h300);
    chk("br_drop_req", 32'(imem_req), 32'd0);
    chk("br_drop_valid", 32'(if_valid), 32'd0);
    expect_next(32'h300);

    // Redirect in REQ without a grant: address simply moves
    gnt_en   = 1'b0;
    imem_gnt = 1'b0;
    redirect(32'h40);
    chk("br_req_req", 32'(imem_req), 32'd1);
    chk("br_req_addr", imem_addr, 32'h40);
    tick();
    chk("br_req_hold_req", 32'(imem_req), 32'd1);
    chk("br_req_hold_addr", imem_addr, 32'h40);
    gnt_en = 1'b1;
    expect_next(32'h40);

    // 32-bit wraparound
    redirect(32'hFFFF_FFF8);
    expect_next(32'hFFFF_FFF8);
    expect_next(32'hFFFF_FFFC);
    expect_next(32'h0000_0000);

    // Misaligned redirect
    redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_set", 32'(fetch_misalign), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("halt_req%0d", i), 32'(imem_req), 32'd0);
      tick();
    end
    chk("misalign_sticky", 32'(fetch_misalign), 32'd1);
    redirect(32'h200);
    chk("misalign_clear", 32'(fetch_misalign), 32'd0);
    expect_next(32'h200);
`else
    chk("misalign_tied", 32'(fetch_misalign), 32'd0);
    expect_next(32'h100);
`endif

    // Asynchronous reset with a response in flight; it must be ignored
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL timeout waiting for a granted request before reset");
    end
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_addr", imem_addr, 32'd0);
    chk("async_rst_valid", 32'(if_valid), 32'd0);
    chk("async_rst_pc", if_pc, 32'd0);
    chk("async_rst_instr", if_instr, 32'd0);
    #1;
    rst_n = 1'b1;
    expect_next(32'd0);
    expect_next(32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
